// File: rtl/ex_div_pkg.sv
// Shared types and constants for the iterative execute-stage divider.
package ex_div_pkg;

   localparam int unsigned DIV_WIDTH = 32;
   localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

   // Quotient reported for a zero divisor.
   localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } div_state_t;

endpackage

// File: rtl/ex_div_step.sv
// One restoring shift-subtract iteration on magnitudes; purely combinational.
module ex_div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH:0]   r_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH:0]   r_o,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH+1:0] r_sh;
   logic [WIDTH+1:0] trial;
   logic             ge;

   // Top bit of trial is the borrow: clear means the divisor fit.
   assign r_sh  = {r_i, q_i[WIDTH-1]};
   assign trial = r_sh - {2'b00, d_i};
   assign ge    = ~trial[WIDTH+1];

   assign r_o = ge ? trial[WIDTH:0] : r_sh[WIDTH:0];
   assign q_o = {q_i[WIDTH-2:0], ge};

endmodule

// File: rtl/ex_div.sv
// Iterative restoring divider returning {remainder, quotient} with a
// Start/Busy/Done handshake; one quotient bit per RUN cycle.
module ex_div
   import ex_div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               Start,
   input  logic               Signed,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               Busy,
   output logic               Done,
   output logic               DivZero,
   output logic               Z,
   output logic               N,
   output logic [2*WIDTH-1:0] Out
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   div_state_t         state_q, state_d;
   logic [WIDTH:0]     r_q, r_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [WIDTH-1:0]   d_q, d_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               negq_q, negq_d;
   logic               negr_q, negr_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               dz_q, dz_d;
   logic               z_q, z_d;
   logic               n_q, n_d;
   logic [2*WIDTH-1:0] out_q, out_d;

   logic [WIDTH:0]     r_step;
   logic [WIDTH-1:0]   q_step;
   logic               sgn_a, sgn_b;
   logic [WIDTH-1:0]   q_fix, r_fix;

   ex_div_step #(.WIDTH(WIDTH)) u_step (
      .r_i (r_q),
      .q_i (q_q),
      .d_i (d_q),
      .r_o (r_step),
      .q_o (q_step)
   );

   assign sgn_a = Signed & A[WIDTH-1];
   assign sgn_b = Signed & B[WIDTH-1];
   assign q_fix = negq_q ? -q_q : q_q;
   assign r_fix = negr_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      dz_d    = dz_q;
      z_d     = z_q;
      n_d     = n_q;
      out_d   = out_q;

      unique case (state_q)
         IDLE: begin
            if (Start) begin
               negq_d = sgn_a ^ sgn_b;
               negr_d = sgn_a;
               if (B == '0) begin
                  out_d   = {A, {WIDTH{1'b1}}};
                  dz_d    = 1'b1;
                  z_d     = 1'b0;
                  n_d     = 1'b1;
                  state_d = DONE;
               end else begin
                  q_d     = sgn_a ? -A : A;
                  d_d     = sgn_b ? -B : B;
                  r_d     = '0;
                  cnt_d   = '0;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            r_d   = r_step;
            q_d   = q_step;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = FIXUP;
            end
         end
         FIXUP: begin
            out_d   = {r_fix, q_fix};
            dz_d    = 1'b0;
            z_d     = (q_fix == '0);
            n_d     = q_fix[WIDTH-1];
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= IDLE;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
         z_q     <= z_d;
         n_q     <= n_d;
         out_q   <= out_d;
      end
   end

   assign Busy    = busy_q;
   assign Done    = done_q;
   assign DivZero = dz_q;
   assign Z       = z_q;
   assign N       = n_q;
   assign Out     = out_q;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed corner cases, random operands
// against an arithmetic reference model, handshake and reset behaviour.
module tb_ex_div;

   logic        Clock;
   logic        Reset;
   logic        Start;
   logic        sgn;
   logic [31:0] A, B;
   logic        Busy, Done, DivZero, Z, N;
   logic [63:0] Out;

   int errors = 0;
   int checks = 0;

   ex_div #(.WIDTH(32)) dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .Start   (Start),
      .Signed  (sgn),
      .A       (A),
      .B       (B),
      .Busy    (Busy),
      .Done    (Done),
      .DivZero (DivZero),
      .Z       (Z),
      .N       (N),
      .Out     (Out)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: plain integer division, truncating toward zero.
   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic s);
      longint sa, sb, q, r;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Drive one operation from an idle negedge; returns observations from the
   // Done cycle and the following cycle, leaving the bench at a negedge.
   task automatic issue_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output int lat, output logic [63:0] o,
                           output logic dz, output logic z, output logic n,
                           output logic busy_done, output logic busy_after,
                           output logic done_after);
      Start = 1'b1; A = a; B = b; sgn = s;
      @(posedge Clock);
      @(negedge Clock);
      Start = 1'b0;
      lat = 1;
      while (!Done && lat < 60) begin
         @(negedge Clock);
         lat++;
      end
      if (!Done) lat = 999;
      o = Out; dz = DivZero; z = Z; n = N; busy_done = Busy;
      @(negedge Clock);
      busy_after = Busy;
      done_after = Done;
   endtask

   task automatic test_reset();
      Reset = 1'b1; Start = 1'b0; sgn = 1'b0; A = '0; B = '0;
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
      checks++;
      if ({Busy, Done, DivZero, Z, N} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b want 00000", {Busy, Done, DivZero, Z, N});
      end
      checks++;
      if (Out !== 64'd0) begin
         errors++;
         $display("FAIL reset_out: got %h want 0", Out);
      end
   endtask

   task automatic test_directed();
      logic [31:0] ta [6] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'h1234_5678, 32'h8000_0000, 32'hFFFF_FFFF};
      logic [31:0] tb [6] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'd1};
      logic        ts [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [63:0] te [6] = '{{32'h2, 32'hE}, {32'hFFFF_FFFE, 32'hFFFF_FFF2},
                              {32'h2, 32'hFFFF_FFF2}, {32'h1234_5678, 32'hFFFF_FFFF},
                              {32'h0, 32'h8000_0000}, {32'h0, 32'hFFFF_FFFF}};
      int lat, exp_lat;
      logic [63:0] o;
      logic dz, z, n, bd, ba, da;
      for (int i = 0; i < 6; i++) begin
         issue_op(ta[i], tb[i], ts[i], lat, o, dz, z, n, bd, ba, da);
         exp_lat = (tb[i] == 32'd0) ? 1 : 34;
         checks++;
         if (lat !== exp_lat) begin
            errors++;
            $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, exp_lat);
         end
         checks++;
         if (o !== te[i]) begin
            errors++;
            $display("FAIL dir%0d_out: got %h want %h", i, o, te[i]);
         end
         checks++;
         if ({dz, z, n} !== {tb[i] == 32'd0, te[i][31:0] == 32'd0, te[i][31]}) begin
            errors++;
            $display("FAIL dir%0d_flags dz/z/n: got %b want %b", i, {dz, z, n},
                     {tb[i] == 32'd0, te[i][31:0] == 32'd0, te[i][31]});
         end
         checks++;
         if ({bd, ba, da} !== 3'b100) begin
            errors++;
            $display("FAIL dir%0d_handshake busy_done/busy_after/done_after: got %b want 100",
                     i, {bd, ba, da});
         end
      end
   endtask

   task automatic test_random();
      int lat, exp_lat;
      logic [63:0] o, e;
      logic dz, z, n, bd, ba, da;
      logic [31:0] a, b;
      logic s;
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1, 2:    b = $urandom_range(1, 15);
            3:       b = 32'hFFFF_FFFF - $urandom_range(0, 15);
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 255);
         s = 1'($urandom_range(0, 1));
         e = model(a, b, s);
         exp_lat = (b == 32'd0) ? 1 : 34;
         issue_op(a, b, s, lat, o, dz, z, n, bd, ba, da);
         checks++;
         if (lat !== exp_lat || o !== e) begin
            errors++;
            $display("FAIL rnd%0d a=%h b=%h s=%0d: got out=%h lat=%0d want out=%h lat=%0d",
                     i, a, b, s, o, lat, e, exp_lat);
         end
         checks++;
         if ({dz, z, n} !== {b == 32'd0, e[31:0] == 32'd0, e[31]}) begin
            errors++;
            $display("FAIL rnd%0d_flags dz/z/n: got %b want %b", i, {dz, z, n},
                     {b == 32'd0, e[31:0] == 32'd0, e[31]});
         end
      end
   endtask

   task automatic test_ignore_start();
      int lat;
      logic [63:0] e1, e3;
      e1 = model(32'd100, 32'd7, 1'b0);
      e3 = model(32'd200, 32'd9, 1'b0);
      Start = 1'b1; A = 32'd100; B = 32'd7; sgn = 1'b0;
      @(posedge Clock);
      for (int c = 1; c <= 35; c++) begin
         @(negedge Clock);
         checks++;
         if (Done !== (c == 34)) begin
            errors++;
            $display("FAIL ign_done_cycle%0d: got %b want %b", c, Done, c == 34);
         end
         if (c == 34 || c == 35) begin
            checks++;
            if (Out !== e1) begin
               errors++;
               $display("FAIL ign_out_cycle%0d: got %h want %h", c, Out, e1);
            end
         end
         Start = (c == 5 || c == 34 || c == 35);
         if (c == 5)  begin A = 32'd1000; B = 32'd3; sgn = 1'b1; end
         if (c == 34) begin A = 32'd77;   B = 32'd0; sgn = 1'b1; end
         if (c == 35) begin A = 32'd200;  B = 32'd9; sgn = 1'b0; end
      end
      @(posedge Clock);
      @(negedge Clock);
      Start = 1'b0;
      checks++;
      if (Busy !== 1'b1) begin
         errors++;
         $display("FAIL ign_accept_busy: got %b want 1", Busy);
      end
      lat = 1;
      while (!Done && lat < 60) begin
         @(negedge Clock);
         lat++;
      end
      checks++;
      if (lat !== 34 || Out !== e3) begin
         errors++;
         $display("FAIL ign_third_op: got out=%h lat=%0d want out=%h lat=34", Out, lat, e3);
      end
      @(negedge Clock);
   endtask

   task automatic test_reset_mid();
      int lat;
      logic [63:0] o;
      logic dz, z, n, bd, ba, da, seen;
      Start = 1'b1; A = 32'd100; B = 32'd7; sgn = 1'b0;
      @(posedge Clock);
      for (int c = 1; c <= 10; c++) begin
         @(negedge Clock);
         Start = 1'b0;
      end
      Reset = 1'b1;
      @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
      checks++;
      if ({Busy, Done, DivZero, Z, N} !== 5'b0 || Out !== 64'd0) begin
         errors++;
         $display("FAIL midreset_state: got flags=%b out=%h want 00000 and 0",
                  {Busy, Done, DivZero, Z, N}, Out);
      end
      seen = 1'b0;
      repeat (40) begin
         @(negedge Clock);
         if (Done || Busy) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL midreset_no_done: got activity=%b want 0", seen);
      end
      issue_op(32'd9, 32'd3, 1'b0, lat, o, dz, z, n, bd, ba, da);
      checks++;
      if (lat !== 34 || o !== {32'd0, 32'd3}) begin
         errors++;
         $display("FAIL midreset_fresh_op: got out=%h lat=%0d want out=%h lat=34",
                  o, lat, {32'd0, 32'd3});
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [63:0] o, e;
      logic dz, z, n, bd, ba, da;
      logic [31:0] a, b;
      for (int i = 0; i < 6; i++) begin
         a = $urandom;
         b = (i == 2) ? 32'd0 : $urandom_range(1, 1000);
         e = model(a, b, 1'b1);
         issue_op(a, b, 1'b1, lat, o, dz, z, n, bd, ba, da);
         checks++;
         if (o !== e || ba !== 1'b0 || da !== 1'b0) begin
            errors++;
            $display("FAIL b2b%0d: got out=%h busy_after=%b done_after=%b want out=%h 0 0",
                     i, o, ba, da, e);
         end
      end
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; sgn = 1'b0; A = '0; B = '0;
      @(negedge Clock);
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
